// File: rtl/toggle_debounce_if.sv
// Button-side bundle of the debouncer: raw button in, clean pulse, level and
// press count out. The master drives the button; the debouncer is the slave.
interface toggle_debounce_if;
  logic       btn;
  logic       en;
  logic       level;
  logic [7:0] presses;

  modport master (
    output btn,
    input  en,
    input  level,
    input  presses
  );

  modport slave (
    input  btn,
    output en,
    output level,
    output presses
  );
endinterface

// File: rtl/toggle_debounce.sv
// Push-button debouncer feeding the toggle flip-flop: 2-FF synchronizer,
// 4-state stability FSM and a wrapping press counter. Each accepted press
// yields exactly one registered single-cycle en pulse; releases never pulse.
module toggle_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  toggle_debounce_if.slave db
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HELD   = 2'd2,
    ARM_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             en_q;
  logic             en_d;
  logic [7:0]       presses_q;
  logic [7:0]       presses_d;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= db.btn;
      sync2 <= sync1;
    end
  end

  // FSM state, stability counter, pulse and press count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      en_q      <= 1'b0;
      presses_q <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      en_q      <= en_d;
      presses_q <= presses_d;
    end
  end

  // Next-state logic: a level change is accepted only after DB_CYCLES
  // consecutive agreeing samples in an ARM state; any reversal aborts.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    en_d      = 1'b0;
    presses_d = presses_q;
    case (state)
      IDLE: begin
        if (sync2) state_d = ARM_HI;
      end
      ARM_HI: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_d   = HELD;
          en_d      = 1'b1;
          presses_d = presses_q + 8'd1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2) state_d = ARM_LO;
      end
      ARM_LO: begin
        if (sync2) begin
          state_d = HELD;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The counter restarts on every state change, including aborts.
    if (state_d != state) cnt_d = '0;
  end

  assign db.en      = en_q;
  assign db.level   = (state == HELD) || (state == ARM_LO);
  assign db.presses = presses_q;

endmodule

// File: tb/tb_toggle_debounce.sv
// Bench for toggle_debounce: two instances (DB_CYCLES=4 and DB_CYCLES=1)
// share one button. A run-length reference model predicts en/level/presses
// and a downstream toggle q per edge; a monitor pops and compares.
module tb_toggle_debounce;

  localparam int unsigned DB_A = 4;
  localparam int unsigned DB_B = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;

  always #5 clk = ~clk;

  toggle_debounce_if ifa ();
  toggle_debounce_if ifb ();

  assign ifa.btn = btn;
  assign ifb.btn = btn;

  toggle_debounce #(.DB_CYCLES(DB_A), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .db    (ifa)
  );

  toggle_debounce #(.DB_CYCLES(DB_B), .CNT_W(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .db    (ifb)
  );

  // Downstream toggle flip-flops driven by each debouncer's en.
  logic qa, qb;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa <= 1'b0;
      qb <= 1'b0;
    end else begin
      if (ifa.en) qa <= ~qa;
      if (ifb.en) qb <= ~qb;
    end
  end

  typedef struct {
    logic       en;
    logic       level;
    logic [7:0] presses;
    logic       q;
  } exp_t;

  exp_t        expq [2][$];
  bit          hist [2][$];
  int unsigned run  [2];
  logic        lvl  [2];
  logic [7:0]  pc   [2];
  logic        mq   [2];
  logic        pen  [2];
  int unsigned dbn  [2] = '{DB_A, DB_B};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: the button reaches the decision logic two edges late;
  // the debounced level flips once the delayed button has disagreed with it
  // on DB+1 consecutive edges. Rising flips pulse and count a press.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (reset) begin
        hist[i].delete();
        hist[i].push_back(1'b0);
        hist[i].push_back(1'b0);
        run[i] = 0;
        lvl[i] = 1'b0;
        pc[i]  = 8'd0;
        mq[i]  = 1'b0;
        pen[i] = 1'b0;
      end else begin
        bit s;
        logic pulse;
        pulse = 1'b0;
        if (pen[i]) mq[i] = ~mq[i];
        s = hist[i].pop_front();
        hist[i].push_back(btn);
        if (s != lvl[i]) begin
          run[i]++;
          if (run[i] == dbn[i] + 1) begin
            lvl[i] = s;
            run[i] = 0;
            if (s) begin
              pulse = 1'b1;
              pc[i] = pc[i] + 8'd1;
            end
          end
        end else begin
          run[i] = 0;
        end
        pen[i] = pulse;
      end
      e.en      = pen[i];
      e.level   = lvl[i];
      e.presses = pc[i];
      e.q       = mq[i];
      expq[i].push_back(e);
    end
  end

  // Monitor: compare every presented output against the scoreboard.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (expq[i].size() != 0) begin
        exp_t e;
        string tag;
        e = expq[i].pop_front();
        tag = (i == 0) ? "a" : "b";
        chk({"en_", tag},      (i == 0) ? int'(ifa.en)      : int'(ifb.en),      int'(e.en));
        chk({"level_", tag},   (i == 0) ? int'(ifa.level)   : int'(ifb.level),   int'(e.level));
        chk({"presses_", tag}, (i == 0) ? int'(ifa.presses) : int'(ifb.presses), int'(e.presses));
        chk({"q_", tag},       (i == 0) ? int'(qa)          : int'(qb),          int'(e.q));
      end
    end
  end

  task automatic drive(input logic b, input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      btn = b;
    end
  endtask

  initial begin
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    btn   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Clean press and release.
    drive(1'b1, 12);
    drive(1'b0, 10);

    // Bounce, then a steady press, then release.
    foreach (pat[k]) drive(pat[k], 1);
    drive(1'b1, 10);
    drive(1'b0, 10);

    // Reset while arming, button held through reset release.
    drive(1'b1, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 10);
    drive(1'b0, 10);

    // Reset while en is high must clear it without waiting for an edge.
    @(negedge clk);
    btn = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("en_async_clear_a", int'(ifa.en), 0);
    chk("presses_async_clear_a", int'(ifa.presses), 0);
    chk("level_async_clear_a", int'(ifa.level), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 10);

    // Random bouncy activity.
    repeat (80) drive(logic'($urandom_range(0, 1)), $urandom_range(1, 7));
    drive(1'b0, 10);

    // Enough clean presses to wrap the press counter.
    repeat (260) begin
      drive(1'b1, 8);
      drive(1'b0, 8);
    end
    drive(1'b0, 5);

    repeat (3) @(posedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
